x9_sequencer: RTL and testbench
===============================

# x9_sequencer

Multi-cycle instruction sequencer for the X9 core. It owns the program counter, the instruction register and the branch flag, and steps each 9-bit instruction through fetch, execute, memory and write-back. It issues qualified strobes to the register file, the data memory and the flag logic, and it sits between the instruction ROM, the opcode decoder and the shared datapath.

## Interface
- PCW, 10: program counter width.
- IW, 9: instruction width. Opcode is IR[IW-1:IW-5].
- CNTW, 16: retired-instruction counter width.

Ports:
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  begins execution. Sampled only in IDLE or DONE.
- StartAddr  in  PCW  PC loaded on Start.
- EndAddr  in  PCW  halt address. Reaching it in FETCH ends the program.
- InstrIn  in  IW  instruction ROM data for the current PC (asynchronous ROM).
- AluFlag  in  1  comparison result from the datapath during EXEC.
- BranchTarget  in  PCW  resolved target for the current IR.
- MemAck  in  1  data memory completion.
- PC  out  PCW  program counter.
- IR  out  IW  instruction register.
- Flag  out  1  stored branch flag.
- RegWriteEn  out  1  one-cycle register file write strobe.
- WbSel  out  1  selects the write-back source: 1 = memory, 0 = ALU.
- MemReq  out  1  data memory request.
- MemWe  out  1  store qualifier, valid while MemReq is high.
- FlagLoad  out  1  asserted while Flag captures AluFlag.
- Busy  out  1  high in FETCH, EXEC, MEM and WB.
- Done  out  1  high in DONE.
- InstrCount  out  CNTW  number of retired instructions.

## Operation
Instruction classes, decoded from the IR opcode:
- ALU/mov: opcodes 00000–00010, 00111–01100, 01111 and 1x???.
- lb: 00011.
- sb: 00100.
- beq: 00101.
- bne: 00110.
- cmp (eq/lt): 01101, 01110.

FSM states are IDLE, FETCH, EXEC, MEM, WB and DONE.

- **IDLE:** on Start, load PC←StartAddr, Flag←0, InstrCount←0, then go to FETCH.
- **FETCH:**
  - If PC==EndAddr, go to DONE and leave IR unchanged.
  - Otherwise load IR←InstrIn and go to EXEC.
- **EXEC:**
  - cmp: assert FlagLoad, load Flag←AluFlag and PC←PC+1, retire, go to FETCH.
  - beq: if Flag==1, PC←BranchTarget; otherwise PC←PC+1. Retire, go to FETCH.
  - bne: if Flag==0, PC←BranchTarget; otherwise PC←PC+1. Retire, go to FETCH.
  - lb/sb: go to MEM.
  - ALU/mov: go to WB.
- **MEM:**
  - Hold MemReq=1. MemWe=1 for sb only.
  - Remain in MEM until MemAck is high.
  - On MemAck with sb: PC←PC+1, retire, go to FETCH.
  - On MemAck with lb: go to WB.
- **WB:** assert RegWriteEn=1, with WbSel=1 for lb and 0 otherwise. Load PC←PC+1, retire, go to FETCH.
- **DONE:** Done=1. On Start, restart exactly as from IDLE.

Rules that apply in every state:
- "Retire" means InstrCount←InstrCount+1, saturating at all-ones.
- PC+1 wraps modulo 2^PCW.
- Start is ignored while Busy.
- MemAck is ignored outside MEM.
- All control outputs (RegWriteEn, WbSel, MemReq, MemWe, FlagLoad, Busy, Done) decode from the state register and IR only. None of them depends combinationally on any input.

## Timing
- Reset (Reset_n low) takes effect immediately, regardless of Clk: state=IDLE and every output is 0, including PC, IR, Flag and InstrCount. MemReq drops at once, even mid-request.
- Per-instruction cycle counts:
  - cmp, beq, bne: 2 cycles (FETCH, EXEC).
  - ALU/mov: 3 cycles (FETCH, EXEC, WB).
  - sb: 3+w cycles (FETCH, EXEC, MEM).
  - lb: 4+w cycles (FETCH, EXEC, MEM, WB).
  - w is the number of MEM cycles with MemAck low. MemAck high in the first MEM cycle gives w=0.
- Start to first FETCH: 1 cycle.
- EndAddr detection to Done: 1 cycle.
- PC, Flag and InstrCount update on the clock edge that leaves the retiring state.
- The new PC is visible in the following FETCH cycle.

## Test plan
- **Reset and start:** hold Reset_n=0 → all outputs 0. Release, then Start with StartAddr=5 and EndAddr=6 over one ALU instruction (add) → PC=5 in FETCH, RegWriteEn for exactly 1 cycle in WB, Done one cycle after PC=6, InstrCount=1.
- **Compare and branch:** cmp with AluFlag=1, then beq with BranchTarget=0x20 → Flag=1 and PC=0x20. Repeat with bne → PC=prev+1.
- **Load with wait states:** lb with MemAck delayed 3 cycles → MemReq high for 4 cycles, MemWe=0, then WB with WbSel=1. Total 7 cycles.
- **Store without wait:** sb with MemAck high in the first MEM cycle → MemReq and MemWe high for 1 cycle, RegWriteEn never high, 3 cycles total.
- **Reset mid-operation:** assert Reset_n low while in MEM → MemReq low immediately, state IDLE. A stray MemAck and a Start pulse while Busy produce no effect.
- **Wrap and saturation:** StartAddr=1023 and EndAddr=1 with ALU instructions → PC goes 1023→0→1 and then Done. With CNTW=2, run 5 instructions → InstrCount holds at 3.

Source files
------------

// File: rtl/x9_sequencer_if.sv
// rtl/x9_sequencer_if.sv - X9 sequencer bus: ROM, datapath, memory and control strobes
// The master side is the sequencer; the slave side is the surrounding core.
interface x9_sequencer_if #(
   parameter int PCW  = 10,
   parameter int IW   = 9,
   parameter int CNTW = 16
);
   logic            Start;
   logic [PCW-1:0]  StartAddr;
   logic [PCW-1:0]  EndAddr;
   logic [IW-1:0]   InstrIn;
   logic            AluFlag;
   logic [PCW-1:0]  BranchTarget;
   logic            MemAck;
   logic [PCW-1:0]  PC;
   logic [IW-1:0]   IR;
   logic            Flag;
   logic            RegWriteEn;
   logic            WbSel;
   logic            MemReq;
   logic            MemWe;
   logic            FlagLoad;
   logic            Busy;
   logic            Done;
   logic [CNTW-1:0] InstrCount;

   modport master (
      input  Start, StartAddr, EndAddr, InstrIn, AluFlag, BranchTarget, MemAck,
      output PC, IR, Flag, RegWriteEn, WbSel, MemReq, MemWe, FlagLoad, Busy, Done, InstrCount
   );

   modport slave (
      output Start, StartAddr, EndAddr, InstrIn, AluFlag, BranchTarget, MemAck,
      input  PC, IR, Flag, RegWriteEn, WbSel, MemReq, MemWe, FlagLoad, Busy, Done, InstrCount
   );
endinterface

// File: rtl/x9_sequencer.sv
// rtl/x9_sequencer.sv - multi-cycle fetch/exec/mem/wb sequencer for the X9 core
// Owns PC, IR, branch flag and the retired-instruction counter.
module x9_sequencer #(
   parameter int PCW  = 10,
   parameter int IW   = 9,
   parameter int CNTW = 16
) (
   input  logic Clk,
   input  logic Reset_n,
   x9_sequencer_if.master bus
);
   typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, WB, DONE} state_t;

   state_t          state, state_nx;
   logic [PCW-1:0]  pc, pc_nx, pc_inc;
   logic [IW-1:0]   ir, ir_nx;
   logic            flag, flag_nx;
   logic [CNTW-1:0] cnt, cnt_nx, cnt_ret;
   logic [4:0]      op;
   logic            is_lb, is_sb, is_beq, is_bne, is_cmp;
   logic            regwrite, wbsel, memreq, memwe, flagload, busy, done;

   assign op     = ir[IW-1:IW-5];
   assign is_lb  = (op == 5'b00011);
   assign is_sb  = (op == 5'b00100);
   assign is_beq = (op == 5'b00101);
   assign is_bne = (op == 5'b00110);
   assign is_cmp = (op == 5'b01101) || (op == 5'b01110);

   assign pc_inc  = pc + PCW'(1);
   assign cnt_ret = (&cnt) ? cnt : cnt + CNTW'(1);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         pc   <= '0;
         ir   <= '0;
         flag <= 1'b0;
         cnt  <= '0;
      end else begin
         pc   <= pc_nx;
         ir   <= ir_nx;
         flag <= flag_nx;
         cnt  <= cnt_nx;
      end
   end

   // Strobes decode from state and IR only; inputs steer next-state values alone.
   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      ir_nx    = ir;
      flag_nx  = flag;
      cnt_nx   = cnt;
      regwrite = 1'b0;
      wbsel    = 1'b0;
      memreq   = 1'b0;
      memwe    = 1'b0;
      flagload = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE, DONE: begin
            done = (state == DONE);
            if (bus.Start) begin
               pc_nx    = bus.StartAddr;
               flag_nx  = 1'b0;
               cnt_nx   = '0;
               state_nx = FETCH;
            end
         end
         FETCH: begin
            busy = 1'b1;
            if (pc == bus.EndAddr) begin
               state_nx = DONE;
            end else begin
               ir_nx    = bus.InstrIn;
               state_nx = EXEC;
            end
         end
         EXEC: begin
            busy     = 1'b1;
            flagload = is_cmp;
            if (is_cmp) begin
               flag_nx  = bus.AluFlag;
               pc_nx    = pc_inc;
               cnt_nx   = cnt_ret;
               state_nx = FETCH;
            end else if (is_beq || is_bne) begin
               pc_nx    = ((is_beq && flag) || (is_bne && !flag)) ? bus.BranchTarget : pc_inc;
               cnt_nx   = cnt_ret;
               state_nx = FETCH;
            end else if (is_lb || is_sb) begin
               state_nx = MEM;
            end else begin
               state_nx = WB;
            end
         end
         MEM: begin
            busy   = 1'b1;
            memreq = 1'b1;
            memwe  = is_sb;
            if (bus.MemAck) begin
               if (is_sb) begin
                  pc_nx    = pc_inc;
                  cnt_nx   = cnt_ret;
                  state_nx = FETCH;
               end else begin
                  state_nx = WB;
               end
            end
         end
         WB: begin
            busy     = 1'b1;
            regwrite = 1'b1;
            wbsel    = is_lb;
            pc_nx    = pc_inc;
            cnt_nx   = cnt_ret;
            state_nx = FETCH;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign bus.PC         = pc;
   assign bus.IR         = ir;
   assign bus.Flag       = flag;
   assign bus.InstrCount = cnt;
   assign bus.RegWriteEn = regwrite;
   assign bus.WbSel      = wbsel;
   assign bus.MemReq     = memreq;
   assign bus.MemWe      = memwe;
   assign bus.FlagLoad   = flagload;
   assign bus.Busy       = busy;
   assign bus.Done       = done;
endmodule

// File: tb/tb_x9_sequencer.sv
// tb/tb_x9_sequencer.sv - directed vector bench for x9_sequencer
module tb_x9_sequencer;
   logic Clk = 1'b0;
   logic Reset_n = 1'b0;

   always #5 Clk = ~Clk;

   x9_sequencer_if #(.PCW(10), .IW(9), .CNTW(16)) bus ();
   x9_sequencer_if #(.PCW(10), .IW(9), .CNTW(2))  bus2 ();

   x9_sequencer #(.PCW(10), .IW(9), .CNTW(16)) dut  (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));
   x9_sequencer #(.PCW(10), .IW(9), .CNTW(2))  dut2 (.Clk(Clk), .Reset_n(Reset_n), .bus(bus2));

   typedef struct {
      logic [8:0] instr;
      logic       alu;
      logic [9:0] tgt;
      int         w;
      logic       stray;
      int         cyc;
      int         n_mreq;
      int         n_mwe;
      int         n_rw;
      int         n_wbs;
      int         n_fl;
      logic [9:0] pc;
      logic       flag;
      int         cnt;
   } vec_t;

   localparam logic [8:0] I_ADD  = 9'b00000_0011;
   localparam logic [8:0] I_LB   = 9'b00011_0001;
   localparam logic [8:0] I_SB   = 9'b00100_0010;
   localparam logic [8:0] I_BEQ  = 9'b00101_0000;
   localparam logic [8:0] I_BNE  = 9'b00110_0000;
   localparam logic [8:0] I_CEQ  = 9'b01101_0000;
   localparam logic [8:0] I_CLT  = 9'b01110_0000;
   localparam logic [8:0] I_MOV  = 9'b01111_0001;
   localparam logic [8:0] I_ALU1 = 9'b10110_1010;

   int pass_cnt = 0;
   int total    = 0;
   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic [8:0] instr, input logic alu, input logic [9:0] tgt,
                               input int w, input logic stray, input int cyc, input int n_mreq,
                               input int n_mwe, input int n_rw, input int n_wbs, input int n_fl,
                               input logic [9:0] pc, input logic flag, input int cnt);
      vec_t v;
      v.instr = instr; v.alu = alu; v.tgt = tgt; v.w = w; v.stray = stray; v.cyc = cyc;
      v.n_mreq = n_mreq; v.n_mwe = n_mwe; v.n_rw = n_rw; v.n_wbs = n_wbs; v.n_fl = n_fl;
      v.pc = pc; v.flag = flag; v.cnt = cnt;
      return v;
   endfunction

   // Entered at the falling edge of the instruction's FETCH cycle; leaves at the next FETCH.
   task automatic run_vec(input string tag, input vec_t v);
      int mseen = 0, nreq = 0, nwe = 0, nrw = 0, nwbs = 0, nfl = 0, nbusy = 0;
      bus.InstrIn      = v.instr;
      bus.AluFlag      = v.alu;
      bus.BranchTarget = v.tgt;
      for (int c = 0; c < v.cyc; c++) begin
         if (bus.MemReq)     nreq++;
         if (bus.MemWe)      nwe++;
         if (bus.RegWriteEn) nrw++;
         if (bus.WbSel)      nwbs++;
         if (bus.FlagLoad)   nfl++;
         if (bus.Busy)       nbusy++;
         bus.MemAck = bus.MemReq ? (mseen == v.w) : v.stray;
         if (bus.MemReq) mseen++;
         @(negedge Clk);
      end
      bus.MemAck = 1'b0;
      chk({tag, " memreq_cycles"}, nreq, v.n_mreq);
      chk({tag, " memwe_cycles"}, nwe, v.n_mwe);
      chk({tag, " regwrite_cycles"}, nrw, v.n_rw);
      chk({tag, " wbsel_cycles"}, nwbs, v.n_wbs);
      chk({tag, " flagload_cycles"}, nfl, v.n_fl);
      chk({tag, " busy_cycles"}, nbusy, v.cyc);
      chk({tag, " ir"}, bus.IR, v.instr);
      chk({tag, " pc"}, bus.PC, v.pc);
      chk({tag, " flag"}, bus.Flag, v.flag);
      chk({tag, " instr_count"}, bus.InstrCount, v.cnt);
   endtask

   initial begin
      bus.Start = 0; bus.StartAddr = '0; bus.EndAddr = '0; bus.InstrIn = '0;
      bus.AluFlag = 0; bus.BranchTarget = '0; bus.MemAck = 0;
      bus2.Start = 0; bus2.StartAddr = '0; bus2.EndAddr = 10'd5; bus2.InstrIn = I_ADD;
      bus2.AluFlag = 0; bus2.BranchTarget = '0; bus2.MemAck = 0;

      vecs[0]  = mk(I_CEQ,  1'b1, 10'h000, 0, 1'b0, 2, 0, 0, 0, 0, 1, 10'h011, 1'b1, 1);
      vecs[1]  = mk(I_BEQ,  1'b0, 10'h020, 0, 1'b0, 2, 0, 0, 0, 0, 0, 10'h020, 1'b1, 2);
      vecs[2]  = mk(I_BNE,  1'b0, 10'h030, 0, 1'b0, 2, 0, 0, 0, 0, 0, 10'h021, 1'b1, 3);
      vecs[3]  = mk(I_CLT,  1'b0, 10'h000, 0, 1'b0, 2, 0, 0, 0, 0, 1, 10'h022, 1'b0, 4);
      vecs[4]  = mk(I_BNE,  1'b1, 10'h040, 0, 1'b0, 2, 0, 0, 0, 0, 0, 10'h040, 1'b0, 5);
      vecs[5]  = mk(I_BEQ,  1'b1, 10'h050, 0, 1'b0, 2, 0, 0, 0, 0, 0, 10'h041, 1'b0, 6);
      vecs[6]  = mk(I_LB,   1'b0, 10'h000, 3, 1'b1, 7, 4, 0, 1, 1, 0, 10'h042, 1'b0, 7);
      vecs[7]  = mk(I_SB,   1'b0, 10'h000, 0, 1'b0, 3, 1, 1, 0, 0, 0, 10'h043, 1'b0, 8);
      vecs[8]  = mk(I_ALU1, 1'b1, 10'h000, 0, 1'b1, 3, 0, 0, 1, 0, 0, 10'h044, 1'b0, 9);
      vecs[9]  = mk(I_SB,   1'b0, 10'h000, 2, 1'b0, 5, 3, 3, 0, 0, 0, 10'h045, 1'b0, 10);
      vecs[10] = mk(I_MOV,  1'b0, 10'h000, 0, 1'b0, 3, 0, 0, 1, 0, 0, 10'h046, 1'b0, 11);
      vecs[11] = mk(I_LB,   1'b0, 10'h000, 0, 1'b0, 4, 1, 0, 1, 1, 0, 10'h047, 1'b0, 12);

      // Reset state
      #12;
      chk("reset outputs",
          {bus.PC, bus.IR, bus.Flag, bus.RegWriteEn, bus.WbSel, bus.MemReq, bus.MemWe,
           bus.FlagLoad, bus.Busy, bus.Done}, 32'h0);
      chk("reset instr_count", bus.InstrCount, 32'h0);

      // Single add from 5 to 6
      @(negedge Clk);
      Reset_n = 1'b1;
      bus.StartAddr = 10'd5; bus.EndAddr = 10'd6; bus.Start = 1'b1; bus2.Start = 1'b1;
      @(negedge Clk);
      bus.Start = 1'b0; bus2.Start = 1'b0;
      chk("start pc", bus.PC, 32'd5);
      chk("start busy", bus.Busy, 32'd1);
      run_vec("add", mk(I_ADD, 1'b0, 10'h000, 0, 1'b0, 3, 0, 0, 1, 0, 0, 10'd6, 1'b0, 1));
      chk("end fetch done", bus.Done, 32'd0);
      @(negedge Clk);
      chk("done", bus.Done, 32'd1);
      chk("done busy", bus.Busy, 32'd0);
      chk("done ir held", bus.IR, I_ADD);
      chk("done count", bus.InstrCount, 32'd1);

      // Restart from DONE and run the vector table
      bus.StartAddr = 10'h010; bus.EndAddr = 10'h3FF; bus.Start = 1'b1;
      @(negedge Clk);
      bus.Start = 1'b0;
      chk("restart pc", bus.PC, 32'h10);
      chk("restart flag", bus.Flag, 32'd0);
      chk("restart count", bus.InstrCount, 32'd0);
      for (int i = 0; i < 12; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

      // Saturating counter instance: five adds from 0 to 5
      chk("sat done", bus2.Done, 32'd1);
      chk("sat pc", bus2.PC, 32'd5);
      chk("sat count", bus2.InstrCount, 32'd3);

      // Reset asserted in the middle of a memory request
      bus.InstrIn = I_LB; bus.MemAck = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      chk("mid memreq before reset", bus.MemReq, 32'd1);
      #2 Reset_n = 1'b0;
      #1;
      chk("mid memreq after reset", bus.MemReq, 32'd0);
      chk("mid busy after reset", bus.Busy, 32'd0);
      chk("mid pc after reset", bus.PC, 32'd0);
      chk("mid ir after reset", bus.IR, 32'd0);
      @(negedge Clk);
      Reset_n = 1'b1;
      bus.MemAck = 1'b1;
      @(negedge Clk);
      @(negedge Clk);
      bus.MemAck = 1'b0;
      chk("stray ack busy", bus.Busy, 32'd0);
      chk("stray ack memreq", bus.MemReq, 32'd0);
      chk("stray ack pc", bus.PC, 32'd0);

      // PC wrap with Start held high while busy
      bus.StartAddr = 10'd1023; bus.EndAddr = 10'd1; bus.Start = 1'b1;
      @(negedge Clk);
      chk("wrap start pc", bus.PC, 32'd1023);
      bus.StartAddr = 10'h155;
      run_vec("wrap0", mk(I_ADD, 1'b0, 10'h000, 0, 1'b1, 3, 0, 0, 1, 0, 0, 10'd0, 1'b0, 1));
      bus.Start = 1'b0;
      run_vec("wrap1", mk(I_ALU1, 1'b0, 10'h000, 0, 1'b0, 3, 0, 0, 1, 0, 0, 10'd1, 1'b0, 2));
      @(negedge Clk);
      chk("wrap done", bus.Done, 32'd1);
      chk("wrap count", bus.InstrCount, 32'd2);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
